recebe_cores: RTL
=================

Name: recebe_cores

Overview:
- Serial receiver for a 3x3 face color frame: the receiving end of the color transmitter's serial protocol.
- Deserializes 9 color bytes from an 8N1 UART line and validates each byte as an ASCII color digit.
- Writes each accepted color into a 3x3 color RAM using the same row/column write interface that identifica_cores drives.
- Used for loopback verification of the color path and to load reference faces into the robot without the camera.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
iniciar  input  1  one-cycle pulse; starts reception of one 9-cell frame
rx_serial  input  1  UART line, idle high, 8N1, LSB first
we_cor  output  1  color RAM write enable, one-cycle pulse per accepted cell
dados_cor  output  3  color code 0..5 for the current write
addr_linha  output  2  RAM row address 0..2
addr_coluna  output  2  RAM column address 0..2
fim  output  1  one-cycle pulse after the 9th cell is written
erro  output  1  sticky flag: invalid or badly framed byte seen in the current frame
db_estado  output  4  current main FSM state encoding, for debug

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; addresses go to (0,0).
  - Main FSM goes to INICIAL; the receive sub-unit goes to IDLE.
  - Reset mid-frame discards the partial frame. RAM contents are not touched.
- rx_serial passes through a 2-flop synchronizer. Its reset value is 1.
- Receive sub-unit:
  - IDLE: waits for a falling edge on the synchronized rx.
  - START: waits DIV/2 clocks, then samples. If the sample is 1, this is a false start: return to IDLE with no byte.
  - DATA: samples 8 bits, each DIV clocks apart, LSB first.
  - STOP: after DIV clocks, samples the stop bit.
    - Stop=1: pulse byte_ok for one cycle with the byte.
    - Stop=0: pulse byte_err for one cycle and discard the byte.
  - Then return to IDLE. The sub-unit runs continuously.
- Main FSM (db_estado encoding in brackets):
  - INICIAL [0]: idle. byte_ok and byte_err are ignored. iniciar=1 -> ZERA.
  - ZERA [1]: addr = (0,0), erro = 0 -> ESPERA.
  - ESPERA [2]:
    - byte_ok -> VALIDA; the byte is latched.
    - byte_err -> erro = 1, stay in ESPERA.
  - VALIDA [3]:
    - Byte in 0x30..0x35 -> ESCREVE, with dados_cor = byte - 0x30 (low 3 bits).
    - Otherwise erro = 1 -> ESPERA; the address does not advance.
  - ESCREVE [4]: we_cor = 1 for exactly this cycle. dados_cor and the addresses are stable in this cycle -> INCREMENTA.
  - INCREMENTA [5]:
    - If (linha,coluna) = (2,2) -> FINAL.
    - Else if coluna = 2: coluna = 0, linha = linha+1 -> ESPERA.
    - Else coluna = coluna+1 -> ESPERA.
  - FINAL [6]: fim = 1 for this cycle -> INICIAL. Addresses hold (2,2) and erro holds its value until the next ZERA.
- Write order is row-major: (0,0),(0,1),(0,2),(1,0)…(2,2). This matches the transmitter's read order.
- Latency: byte_ok to we_cor = 2 clocks. The last stop-bit sample to fim ≈ 4 clocks.
- iniciar while not in INICIAL is ignored.
- A byte completing while the FSM is in VALIDA/ESCREVE/INCREMENTA cannot occur. A byte takes 10·DIV clocks and the FSM returns to ESPERA within 3 clocks.
- dados_cor holds its last value outside ESCREVE. we_cor is never asserted outside ESCREVE.
- There is no timeout: the FSM waits in ESPERA indefinitely until 9 valid cells arrive or reset is applied.

Test Plan:
- Nominal frame: iniciar, then send "012345012" at BAUD -> 9 we_cor pulses with (linha,coluna,dados_cor) = (0,0,0),(0,1,1),(0,2,2),(1,0,3),(1,1,4),(1,2,5),(2,0,0),(2,1,1),(2,2,2). fim pulses once, erro = 0.
- Invalid byte: send "01X2345012" ('X' = 0x58) -> erro = 1 after 'X'. The 'X' is not written and the address stays at (0,2). The frame still completes with 9 writes and fim; erro stays 1 until the next iniciar.
- Framing error: 3rd byte sent with stop bit = 0 -> no write for that byte, erro = 1. The next valid byte is written to (0,2).
- False start: a 1-clock low glitch on an idle rx -> no byte_ok, no write, FSM stays in ESPERA.
- Idle and reentry: send "555" before iniciar -> no writes. iniciar pulsed mid-frame -> ignored, address sequence unaffected.
- Reset mid-frame: reset=0 after 4 cells -> all outputs 0, db_estado = 0. A new iniciar plus 9 bytes restarts writing at (0,0).

Source files
------------

// File: rtl/recebe_cores.sv
// recebe_cores: 8N1 serial receiver that loads a 3x3 face into the colour RAM.
// Each accepted ASCII digit '0'..'5' becomes one row-major RAM write.
module recebe_cores #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       rx_serial,
    output logic       we_cor,
    output logic [2:0] dados_cor,
    output logic [1:0] addr_linha,
    output logic [1:0] addr_coluna,
    output logic       fim,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    // Receive sub-unit states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Main FSM states (encoding is visible on db_estado)
    localparam logic [3:0] INICIAL    = 4'd0;
    localparam logic [3:0] ZERA       = 4'd1;
    localparam logic [3:0] ESPERA     = 4'd2;
    localparam logic [3:0] VALIDA     = 4'd3;
    localparam logic [3:0] ESCREVE    = 4'd4;
    localparam logic [3:0] INCREMENTA = 4'd5;
    localparam logic [3:0] FINAL      = 4'd6;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       rx_estado_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             byte_ok_q, byte_err_q;

    logic [3:0] estado_q, estado_d;
    logic [7:0] byte_q, byte_d;
    logic [1:0] linha_q, linha_d;
    logic [1:0] coluna_q, coluna_d;
    logic [2:0] dados_q, dados_d;
    logic       erro_q, erro_d;
    logic       byte_valido;

    // Two-flop synchronizer plus one delay stage for falling-edge detection; idle level is 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit-level receiver: centre-samples each bit and flags good/bad stop bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_estado_q <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            byte_ok_q   <= 1'b0;
            byte_err_q  <= 1'b0;
        end else begin
            byte_ok_q  <= 1'b0;
            byte_err_q <= 1'b0;
            case (rx_estado_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_estado_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        // Line back high at mid start bit: glitch, not a frame
                        rx_estado_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) begin
                            rx_estado_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q    <= '0;
                        byte_ok_q   <= rx_sync_q;
                        byte_err_q  <= !rx_sync_q;
                        rx_estado_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_estado_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valido = (byte_q >= 8'h30) && (byte_q <= 8'h35);

    // Main FSM next-state: validate each byte and walk the RAM row-major
    always_comb begin
        estado_d = estado_q;
        byte_d   = byte_q;
        linha_d  = linha_q;
        coluna_d = coluna_q;
        dados_d  = dados_q;
        erro_d   = erro_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d = ZERA;
                end
            end
            ZERA: begin
                linha_d  = 2'd0;
                coluna_d = 2'd0;
                erro_d   = 1'b0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (byte_ok_q) begin
                    byte_d   = rx_shift_q;
                    estado_d = VALIDA;
                end else if (byte_err_q) begin
                    erro_d = 1'b1;
                end
            end
            VALIDA: begin
                if (byte_valido) begin
                    // 0x30 has zero low bits, so the low 3 bits are already byte - 0x30
                    dados_d  = byte_q[2:0];
                    estado_d = ESCREVE;
                end else begin
                    erro_d   = 1'b1;
                    estado_d = ESPERA;
                end
            end
            ESCREVE: estado_d = INCREMENTA;
            INCREMENTA: begin
                if (linha_q == 2'd2 && coluna_q == 2'd2) begin
                    estado_d = FINAL;
                end else if (coluna_q == 2'd2) begin
                    coluna_d = 2'd0;
                    linha_d  = linha_q + 1'b1;
                    estado_d = ESPERA;
                end else begin
                    coluna_d = coluna_q + 1'b1;
                    estado_d = ESPERA;
                end
            end
            FINAL:   estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    // Main FSM state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            byte_q   <= '0;
            linha_q  <= '0;
            coluna_q <= '0;
            dados_q  <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            byte_q   <= byte_d;
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
            dados_q  <= dados_d;
            erro_q   <= erro_d;
        end
    end

    // Outputs decoded from state so we_cor and fim are exactly one cycle wide
    always_comb begin
        we_cor      = (estado_q == ESCREVE);
        fim         = (estado_q == FINAL);
        dados_cor   = dados_q;
        addr_linha  = linha_q;
        addr_coluna = coluna_q;
        erro        = erro_q;
        db_estado   = estado_q;
    end

endmodule
